line_buf_sched: RTL and testbench

Scheduler for a ring of `line_buf` instances that forms a vertical sliding window of `BUF_CNT-1` video lines for 2-D filters. It sits between the input AXI4-Stream demux and the output row mux of a window generator. It steers each incoming line to the next free buffer, releases all window rows together with simultaneous pops, and flushes the oldest row once the window has been read. It is the only block that drives `pop_line_i` and `flush_line_i` of the buffers.

---
 rtl/line_buf_sched.sv | 149 ++++++++++++++
 tb/tb_line_buf_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_sched.sv
// line_buf_sched: steers input lines into a ring of BUF_CNT line buffers and
// releases WIN = BUF_CNT-1 rows together as a sliding vertical window.
// Latency: pop_o two cycles after the eol_i completing a window (one cycle after
// empty_i clears). Flow control: a window is held in READ until out_done_i;
// an eol_i into a full ring is dropped and raises the sticky ovf_o.
// Ports: clk_i/rst_i (async active-low), sof_i/eol_i input-side handshakes,
// empty_i per-buffer status, out_done_i output-side tlast, wr_sel_o/rd_base_o
// ring indices, pop_o/flush_o per-buffer strobes, fill_o, busy_o, win_cnt_o,
// ovf_o.
module line_buf_sched #(
  parameter  int BUF_CNT   = 4,
  parameter  int CNT_WIDTH = 16,
  localparam int IW        = $clog2(BUF_CNT),
  localparam int FW        = $clog2(BUF_CNT+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sof_i,
  input  logic                 eol_i,
  input  logic [BUF_CNT-1:0]   empty_i,
  input  logic                 out_done_i,
  output logic [IW-1:0]        wr_sel_o,
  output logic [IW-1:0]        rd_base_o,
  output logic [BUF_CNT-1:0]   pop_o,
  output logic [BUF_CNT-1:0]   flush_o,
  output logic [FW-1:0]        fill_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] win_cnt_o,
  output logic                 ovf_o
);

  localparam int WIN = BUF_CNT - 1;
  localparam logic [BUF_CNT-1:0] WIN_BASE = {1'b0, {WIN{1'b1}}};

  typedef enum logic [1:0] {IDLE, POP, READ, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        wr_sel_q, wr_sel_d;
  logic [IW-1:0]        rd_base_q, rd_base_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [CNT_WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [BUF_CNT-1:0]   pop_q, pop_d;
  logic [BUF_CNT-1:0]   flush_q, flush_d;
  logic                 busy_q, busy_d;

  logic [2*BUF_CNT-1:0] win_dbl;
  logic [BUF_CNT-1:0]   win_mask;
  logic                 win_ready;
  logic                 flush_now;
  logic                 eol_take;

  // Ring indices wrap at BUF_CNT-1, which need not be a power of two.
  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
    return (i == IW'(BUF_CNT-1)) ? '0 : i + 1'b1;
  endfunction

  // Rotate the WIN-row mask left by rd_base; the upper half folds back to
  // the low bits to form the modulo-BUF_CNT wrap.
  assign win_dbl   = {{BUF_CNT{1'b0}}, WIN_BASE} << rd_base_q;
  assign win_mask  = win_dbl[BUF_CNT-1:0] | win_dbl[2*BUF_CNT-1:BUF_CNT];
  assign win_ready = ~|(win_mask & empty_i);

  assign flush_now = (state_q == FLUSH);
  // A full ring can still take a line when the oldest row is freed this cycle.
  assign eol_take  = eol_i && ((fill_q != FW'(BUF_CNT)) || flush_now);

  always_comb begin
    state_d   = state_q;
    wr_sel_d  = wr_sel_q;
    rd_base_d = rd_base_q;
    fill_d    = fill_q;
    win_cnt_d = win_cnt_q;
    ovf_d     = ovf_q;
    pop_d     = '0;
    flush_d   = '0;
    busy_d    = 1'b0;

    if (sof_i) begin
      // New frame: drop all buffered lines and restart the window count.
      state_d   = IDLE;
      wr_sel_d  = '0;
      rd_base_d = '0;
      fill_d    = '0;
      win_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE:    if ((fill_q >= FW'(WIN)) && win_ready) state_d = POP;
        POP:     state_d = READ;
        READ:    if (out_done_i) state_d = FLUSH;
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (eol_i && !eol_take) ovf_d = 1'b1;
      if (eol_take) wr_sel_d = idx_inc(wr_sel_q);
      if (flush_now) begin
        rd_base_d = idx_inc(rd_base_q);
        win_cnt_d = win_cnt_q + 1'b1;
      end

      case ({eol_take, flush_now})
        2'b10:   fill_d = fill_q + 1'b1;
        2'b01:   fill_d = fill_q - 1'b1;
        default: fill_d = fill_q;
      endcase

      // Strobes are registered alongside the state they belong to.
      pop_d   = (state_d == POP)   ? win_mask : '0;
      flush_d = (state_d == FLUSH) ? (BUF_CNT'(1) << rd_base_q) : '0;
      busy_d  = (state_d == READ);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      wr_sel_q  <= '0;
      rd_base_q <= '0;
      fill_q    <= '0;
      win_cnt_q <= '0;
      ovf_q     <= 1'b0;
      pop_q     <= '0;
      flush_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_sel_q  <= wr_sel_d;
      rd_base_q <= rd_base_d;
      fill_q    <= fill_d;
      win_cnt_q <= win_cnt_d;
      ovf_q     <= ovf_d;
      pop_q     <= pop_d;
      flush_q   <= flush_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_sel_o  = wr_sel_q;
  assign rd_base_o = rd_base_q;
  assign fill_o    = fill_q;
  assign win_cnt_o = win_cnt_q;
  assign ovf_o     = ovf_q;
  assign pop_o     = pop_q;
  assign flush_o   = flush_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_line_buf_sched.sv
// Bench for line_buf_sched with BUF_CNT=4: a small buffer model drives empty_i,
// pop/flush strobes are checked against scoreboard queues, register outputs
// are checked inline by each scenario task.
module tb_line_buf_sched;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sof_i = 1'b0;
  logic        eol_i = 1'b0;
  logic        out_done_i = 1'b0;
  logic [3:0]  empty_i;
  logic [1:0]  wr_sel_o, rd_base_o;
  logic [3:0]  pop_o, flush_o;
  logic [2:0]  fill_o;
  logic        busy_o;
  logic [15:0] win_cnt_o;
  logic        ovf_o;

  int total = 0;
  int bad   = 0;

  logic [3:0] pop_exp[$];
  logic [3:0] flush_exp[$];
  logic [3:0] pop_tab[4];
  logic [3:0] mon_p, mon_f;

  // Buffer model: a line becomes visible (empty low) one cycle after its eol,
  // a flush empties the buffer, SOF or reset empties everything.
  logic [3:0] empty_m;
  logic       pend;
  logic [1:0] pend_idx;
  assign empty_i = empty_m;

  always #5 clk_i = ~clk_i;

  line_buf_sched #(.BUF_CNT(4), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sof_i(sof_i), .eol_i(eol_i),
    .empty_i(empty_i), .out_done_i(out_done_i), .wr_sel_o(wr_sel_o),
    .rd_base_o(rd_base_o), .pop_o(pop_o), .flush_o(flush_o), .fill_o(fill_o),
    .busy_o(busy_o), .win_cnt_o(win_cnt_o), .ovf_o(ovf_o)
  );

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      empty_m <= 4'hF; pend <= 1'b0; pend_idx <= 2'd0;
    end else if (sof_i) begin
      empty_m <= 4'hF; pend <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (pend && int'(pend_idx) == b) empty_m[b] <= 1'b0;
        else if (flush_o[b])             empty_m[b] <= 1'b1;
      end
      pend     <= eol_i;
      pend_idx <= wr_sel_o;
    end
  end

  // Scoreboard for the per-buffer strobes.
  always @(negedge clk_i) begin
    if (pop_o !== 4'b0000) begin
      total++;
      if (pop_exp.size() == 0) begin
        bad++; $display("FAIL unexpected_pop got=%b want=none", pop_o);
      end else begin
        mon_p = pop_exp.pop_front();
        if (pop_o !== mon_p) begin bad++; $display("FAIL pop_mask got=%b want=%b", pop_o, mon_p); end
      end
    end
    if (flush_o !== 4'b0000) begin
      total++;
      if (flush_exp.size() == 0) begin
        bad++; $display("FAIL unexpected_flush got=%b want=none", flush_o);
      end else begin
        mon_f = flush_exp.pop_front();
        if (flush_o !== mon_f) begin bad++; $display("FAIL flush_mask got=%b want=%b", flush_o, mon_f); end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_line();
    repeat (7) @(negedge clk_i);
    eol_i = 1'b1;
    @(negedge clk_i);
    eol_i = 1'b0;
  endtask

  task automatic do_sof();
    @(negedge clk_i); sof_i = 1'b1;
    @(negedge clk_i); sof_i = 1'b0;
  endtask

  task automatic wait_busy(output bit ok);
    int n;
    n = 0;
    while (busy_o !== 1'b1 && n < 30) begin @(negedge clk_i); n++; end
    ok = (busy_o === 1'b1);
  endtask

  task automatic drain(input logic [3:0] fmask);
    flush_exp.push_back(fmask);
    @(negedge clk_i); out_done_i = 1'b1;
    @(negedge clk_i); out_done_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b0;
    #10;
    total++;
    if ({wr_sel_o, rd_base_o, pop_o, flush_o, fill_o, busy_o, win_cnt_o, ovf_o} !== 36'd0) begin
      bad++; $display("FAIL reset_values got=%h want=0",
                      {wr_sel_o, rd_base_o, pop_o, flush_o, fill_o, busy_o, win_cnt_o, ovf_o});
    end
    @(negedge clk_i); rst_i = 1'b1;
    tick(2);
  endtask

  task automatic test_first_window();
    bit ok;
    do_sof();
    send_line(); send_line();
    total++; if (fill_o !== 3'd2) begin bad++; $display("FAIL fw_fill2 got=%0d want=2", fill_o); end
    pop_exp.push_back(4'b0111);
    send_line();
    wait_busy(ok);
    total++; if (!ok) begin bad++; $display("FAIL fw_busy_timeout busy=%b want=1", busy_o); end
    tick(3);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL fw_busy_hold got=%b want=1", busy_o); end
    drain(4'b0001);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL fw_busy_fall got=%b want=0", busy_o); end
    tick(1);
    total++; if (rd_base_o !== 2'd1) begin bad++; $display("FAIL fw_rd_base got=%0d want=1", rd_base_o); end
    total++; if (fill_o !== 3'd2) begin bad++; $display("FAIL fw_fill got=%0d want=2", fill_o); end
    total++; if (win_cnt_o !== 16'd1) begin bad++; $display("FAIL fw_win_cnt got=%0d want=1", win_cnt_o); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [3:0] f;
    do_sof();
    send_line(); send_line();
    for (int i = 0; i < 8; i++) begin
      pop_exp.push_back(pop_tab[i % 4]);
      send_line();
      if (i == 1) begin
        total++; if (wr_sel_o !== 2'd0) begin bad++; $display("FAIL wrap_wr_sel got=%0d want=0", wr_sel_o); end
      end
      wait_busy(ok);
      total++; if (!ok) begin bad++; $display("FAIL wrap_busy_timeout win=%0d", i); end
      f = 4'b0001 << (i % 4);
      drain(f);
      tick(2);
    end
    total++; if (win_cnt_o !== 16'd8) begin bad++; $display("FAIL wrap_win_cnt got=%0d want=8", win_cnt_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b want=0", ovf_o); end
    total++; if (wr_sel_o !== 2'd2) begin bad++; $display("FAIL wrap_wr_sel_end got=%0d want=2", wr_sel_o); end
    total++; if (rd_base_o !== 2'd0) begin bad++; $display("FAIL wrap_rd_base got=%0d want=0", rd_base_o); end
    total++; if (fill_o !== 3'd2) begin bad++; $display("FAIL wrap_fill got=%0d want=2", fill_o); end
    // out_done outside READ must not produce a flush or count a window.
    @(negedge clk_i); out_done_i = 1'b1;
    @(negedge clk_i); out_done_i = 1'b0;
    tick(3);
    total++; if (win_cnt_o !== 16'd8) begin bad++; $display("FAIL idle_done_win_cnt got=%0d want=8", win_cnt_o); end
  endtask

  task automatic test_simul_eol_flush();
    bit ok;
    do_sof();
    send_line(); send_line();
    pop_exp.push_back(4'b0111);
    send_line();
    wait_busy(ok);
    total++; if (!ok) begin bad++; $display("FAIL sim_busy_timeout busy=%b want=1", busy_o); end
    flush_exp.push_back(4'b0001);
    pop_exp.push_back(4'b1110);
    @(negedge clk_i); out_done_i = 1'b1;
    @(negedge clk_i); out_done_i = 1'b0; eol_i = 1'b1;
    @(negedge clk_i); eol_i = 1'b0;
    total++; if (fill_o !== 3'd3) begin bad++; $display("FAIL sim_fill got=%0d want=3", fill_o); end
    total++; if (wr_sel_o !== 2'd0) begin bad++; $display("FAIL sim_wr_sel got=%0d want=0", wr_sel_o); end
    total++; if (rd_base_o !== 2'd1) begin bad++; $display("FAIL sim_rd_base got=%0d want=1", rd_base_o); end
    wait_busy(ok);
    total++; if (!ok) begin bad++; $display("FAIL sim_busy2_timeout busy=%b want=1", busy_o); end
    drain(4'b0010);
    tick(2);
  endtask

  task automatic test_overflow();
    do_sof();
    send_line(); send_line();
    pop_exp.push_back(4'b0111);
    send_line(); send_line();
    total++; if (fill_o !== 3'd4) begin bad++; $display("FAIL ovf_fill4 got=%0d want=4", fill_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", ovf_o); end
    send_line();
    total++; if (fill_o !== 3'd4) begin bad++; $display("FAIL ovf_fill_sat got=%0d want=4", fill_o); end
    total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf_o); end
    total++; if (wr_sel_o !== 2'd0) begin bad++; $display("FAIL ovf_wr_sel got=%0d want=0", wr_sel_o); end
  endtask

  task automatic test_sof_mid_window();
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL sof_pre_busy got=%b want=1", busy_o); end
    @(negedge clk_i); sof_i = 1'b1; eol_i = 1'b1;
    @(negedge clk_i); sof_i = 1'b0; eol_i = 1'b0;
    total++;
    if ({wr_sel_o, rd_base_o, pop_o, flush_o, fill_o, busy_o, win_cnt_o, ovf_o} !== 36'd0) begin
      bad++; $display("FAIL sof_clear got=%h want=0",
                      {wr_sel_o, rd_base_o, pop_o, flush_o, fill_o, busy_o, win_cnt_o, ovf_o});
    end
    @(negedge clk_i); out_done_i = 1'b1;
    @(negedge clk_i); out_done_i = 1'b0;
    tick(4);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL sof_busy_after got=%b want=0", busy_o); end
    total++; if (fill_o !== 3'd0) begin bad++; $display("FAIL sof_fill_after got=%0d want=0", fill_o); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int n;
    do_sof();
    send_line(); send_line();
    pop_exp.push_back(4'b0111);
    send_line();
    n = 0;
    while (pop_o === 4'b0000 && n < 10) begin @(negedge clk_i); n++; end
    total++; if (pop_o === 4'b0000) begin bad++; $display("FAIL ar_pop_timeout got=%b want=0111", pop_o); end
    #1 rst_i = 1'b0;
    #1;
    total++; if (pop_o !== 4'b0000) begin bad++; $display("FAIL ar_pop_clear got=%b want=0000", pop_o); end
    total++; if (wr_sel_o !== 2'd0) begin bad++; $display("FAIL ar_wr_sel got=%0d want=0", wr_sel_o); end
    total++; if (fill_o !== 3'd0) begin bad++; $display("FAIL ar_fill got=%0d want=0", fill_o); end
    @(negedge clk_i);
    @(negedge clk_i); rst_i = 1'b1;
    send_line(); send_line();
    total++; if (fill_o !== 3'd2) begin bad++; $display("FAIL ar_fill2 got=%0d want=2", fill_o); end
    tick(6);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ar_early_busy got=%b want=0", busy_o); end
    pop_exp.push_back(4'b0111);
    send_line();
    wait_busy(ok);
    total++; if (!ok) begin bad++; $display("FAIL ar_busy_timeout busy=%b want=1", busy_o); end
    drain(4'b0001);
    tick(2);
    total++; if (win_cnt_o !== 16'd1) begin bad++; $display("FAIL ar_win_cnt got=%0d want=1", win_cnt_o); end
  endtask

  initial begin
    pop_tab[0] = 4'b0111;
    pop_tab[1] = 4'b1110;
    pop_tab[2] = 4'b1101;
    pop_tab[3] = 4'b1011;
    test_reset();
    test_first_window();
    test_wrap();
    test_simul_eol_flush();
    test_overflow();
    test_sof_mid_window();
    test_async_reset();
    tick(2);
    total++; if (pop_exp.size() != 0) begin bad++; $display("FAIL pop_missing left=%0d want=0", pop_exp.size()); end
    total++; if (flush_exp.size() != 0) begin bad++; $display("FAIL flush_missing left=%0d want=0", flush_exp.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
